// File: rtl/uram_result_drain_if.sv
// Bundles the command/status, tile URAM read port and output stream of
// uram_result_drain. The drain engine uses the master view, the host/tile
// side uses the slave view.
interface uram_result_drain_if #(
    parameter int URAM_A_W = 23,
    parameter int URAM_D_W = 72
);
    logic                start;
    logic [URAM_A_W-1:0] base_addr;
    logic [URAM_A_W:0]   num_words;
    logic                busy;
    logic                done;

    logic [URAM_A_W-1:0] uram2_rd_addr_external;
    logic                read_en_external;
    logic [URAM_D_W-1:0] uram2_rd_data;

    logic [URAM_D_W-1:0] m_data;
    logic                m_valid;
    logic                m_ready;
    logic                m_last;

    modport master (
        input  start, base_addr, num_words, uram2_rd_data, m_ready,
        output busy, done, uram2_rd_addr_external, read_en_external,
               m_data, m_valid, m_last
    );

    modport slave (
        output start, base_addr, num_words, uram2_rd_data, m_ready,
        input  busy, done, uram2_rd_addr_external, read_en_external,
               m_data, m_valid, m_last
    );
endinterface

// File: rtl/uram_result_drain.sv
// Drains a contiguous address range out of a tile's result URAM and streams
// the words out on valid/ready. Reads are only issued when the output buffer
// is guaranteed to have room for them when they return, so backpressure
// never loses data.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for start; captures base_addr/num_words
//   S_ISSUE | issuing reads while credit allows
//   S_DRAIN | all reads issued; waiting for the last word to be accepted
//   S_DONE  | one-cycle done pulse
module uram_result_drain #(
    parameter int URAM_A_W   = 23,
    parameter int URAM_D_W   = 72,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uram_result_drain_if.master  bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [URAM_A_W:0] ONE_WORD = (URAM_A_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Remaining-reads down-counter; zero means the burst is fully issued.
    logic [URAM_A_W:0]     r_remain;
    logic [URAM_A_W-1:0]   r_addr_nxt;
    logic [URAM_A_W-1:0]   r_addr_hold;

    logic [RD_LAT-1:0]     r_pipe_v;
    logic [RD_LAT-1:0]     r_pipe_l;
    logic [CNT_W-1:0]      r_inflight;

    logic [URAM_D_W-1:0]   r_mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_mem_l;
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_accept;
    logic                  w_credit_ok;
    logic                  w_rd_en;
    logic                  w_last_rd;
    logic                  w_ret;
    logic                  w_ret_last;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_head_last;
    logic                  w_final_hs;

    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_accept    = (r_state == S_IDLE) && bus.start;
    // Conservative credit: a pop in this same cycle is not counted.
    assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, r_count}) < DEPTH_C;
    assign w_rd_en     = (r_state == S_ISSUE) && (r_remain != '0) && w_credit_ok;
    assign w_last_rd   = w_rd_en && (r_remain == ONE_WORD);
    assign w_ret       = r_pipe_v[RD_LAT-1];
    assign w_ret_last  = r_pipe_l[RD_LAT-1];
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && bus.m_ready;
    assign w_head_last = r_mem_l[r_rptr];
    assign w_final_hs  = w_pop && w_head_last;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.num_words != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (w_last_rd) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_final_hs) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode; stream outputs are forced to zero while the buffer is empty.
    always_comb begin
        bus.busy                   = (r_state == S_ISSUE) || (r_state == S_DRAIN);
        bus.done                   = (r_state == S_DONE);
        bus.read_en_external       = w_rd_en;
        bus.uram2_rd_addr_external = w_rd_en ? r_addr_nxt : r_addr_hold;
        bus.m_valid                = w_valid;
        bus.m_data                 = w_valid ? r_mem_d[r_rptr] : '0;
        bus.m_last                 = w_valid && w_head_last;
    end

    // Command capture, remaining-reads counter and read address generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remain    <= '0;
            r_addr_nxt  <= '0;
            r_addr_hold <= '0;
        end else if (w_accept) begin
            r_remain   <= bus.num_words;
            r_addr_nxt <= bus.base_addr;
        end else if (w_rd_en) begin
            r_remain    <= r_remain - 1'b1;
            r_addr_nxt  <= r_addr_nxt + 1'b1;
            r_addr_hold <= r_addr_nxt;
        end
    end

    // Read-latency pipe: valid and last-word flag travel with each read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_v <= '0;
            r_pipe_l <= '0;
        end else begin
            r_pipe_v[0] <= w_rd_en;
            r_pipe_l[0] <= w_last_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_l[i] <= r_pipe_l[i-1];
            end
        end
    end

    // Count of reads issued whose data has not yet landed in the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_rd_en, w_ret})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Buffer storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (w_ret) begin
            r_mem_d[r_wptr] <= bus.uram2_rd_data;
            r_mem_l[r_wptr] <= w_ret_last;
        end
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_ret) begin
                r_wptr <= f_ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end
            case ({w_ret, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
